reg_sort_ctrl: RTL and testbench

//  Command initiator for the 8x4 swap register file: sorts its contents in place with bubble sort.

---
 rtl/reg_sort_pkg.sv | 17 +
 rtl/sort_pair_cmp.sv | 18 +
 rtl/reg_sort_ctrl.sv | 173 +++++++++++++++++
 tb/tb_reg_sort_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_sort_pkg.sv
// rtl/reg_sort_pkg.sv - shared types and constants for the register-file bubble sort controller
//
// Purpose : state encoding for the sort FSM and the width of the swap counter.
// Ports   : none (package).
package reg_sort_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        CMP  = 3'd2,
        SWAP = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int SWAP_CNT_W = 6;

endpackage

// File: rtl/sort_pair_cmp.sv
// rtl/sort_pair_cmp.sv - combinational out-of-order test for one adjacent register pair
//
// Purpose : flags a pair (a = r[j], b = r[j+1]) that must be swapped to reach the
//           requested sort direction. Equal values are never out of order.
// Ports   : a, b         in  W  values of the lower and upper index of the pair
//           out_of_order out 1  1 when the pair must be swapped
module sort_pair_cmp #(
    parameter int W          = 4,
    parameter bit DESCENDING = 1'b1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_of_order
);

    assign out_of_order = DESCENDING ? (a < b) : (a > b);

endmodule

// File: rtl/reg_sort_ctrl.sv
// rtl/reg_sort_ctrl.sv - bubble-sort command initiator for the swap register file
//
// Purpose : sorts the register file in place by issuing init/x/y/swap commands and
//           reading back r_in. Passes shrink by one each time; a pass with no swap
//           ends the sort early. Swap and pass counts are kept for display.
// Ports   : clk, reset_n        clock, asynchronous active-low reset
//           start, use_init     sort request (accepted in IDLE/DONE), optional init pulse
//           r_in                register file contents, combinational read
//           init, x, y, swap    registered commands to the register file
//           busy, done          status levels
//           swap_cnt, pass_cnt  statistics of the current/last sort
module reg_sort_ctrl
    import reg_sort_pkg::*;
#(
    parameter  int N_REGS     = 8,
    parameter  int W          = 4,
    parameter  bit DESCENDING = 1'b1,
    localparam int AW         = $clog2(N_REGS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      use_init,
    input  logic [N_REGS-1:0][W-1:0]  r_in,
    output logic                      init,
    output logic [AW-1:0]             x,
    output logic [AW-1:0]             y,
    output logic                      swap,
    output logic                      busy,
    output logic                      done,
    output logic [SWAP_CNT_W-1:0]     swap_cnt,
    output logic [AW-1:0]             pass_cnt
);

    localparam logic [AW-1:0] ONE        = AW'(1);
    localparam logic [AW-1:0] LIMIT_INIT = AW'(N_REGS - 1);

    state_t                  state_q, state_d;
    logic [AW-1:0]           j_q, j_d;
    logic [AW-1:0]           limit_q, limit_d;
    logic                    dirty_q, dirty_d;
    logic [SWAP_CNT_W-1:0]   swap_cnt_q, swap_cnt_d;
    logic [AW-1:0]           pass_cnt_q, pass_cnt_d;
    logic [AW-1:0]           x_q, x_d;
    logic [AW-1:0]           y_q, y_d;
    logic                    init_q, init_d;
    logic                    swap_q, swap_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    out_of_order;
    logic                    advance;

    sort_pair_cmp #(
        .W          (W),
        .DESCENDING (DESCENDING)
    ) u_cmp (
        .a            (r_in[j_q]),
        .b            (r_in[j_q + ONE]),
        .out_of_order (out_of_order)
    );

    always_comb begin
        state_d    = state_q;
        j_d        = j_q;
        limit_d    = limit_q;
        dirty_d    = dirty_q;
        swap_cnt_d = swap_cnt_q;
        pass_cnt_d = pass_cnt_q;
        advance    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    swap_cnt_d = '0;
                    pass_cnt_d = '0;
                    j_d        = '0;
                    limit_d    = LIMIT_INIT;
                    dirty_d    = 1'b0;
                    state_d    = use_init ? INIT : CMP;
                end
            end
            INIT: begin
                state_d = CMP;
            end
            CMP: begin
                if (out_of_order) begin
                    state_d = SWAP;
                end else begin
                    advance = 1'b1;
                end
            end
            SWAP: begin
                dirty_d = 1'b1;
                if (swap_cnt_q != '1) begin
                    swap_cnt_d = swap_cnt_q + SWAP_CNT_W'(1);
                end
                advance = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // dirty_d already includes a swap issued this cycle, so a pass whose only
        // swap was its final pair still triggers another pass.
        if (advance) begin
            if ((j_q + ONE) < limit_q) begin
                j_d     = j_q + ONE;
                state_d = CMP;
            end else begin
                pass_cnt_d = pass_cnt_q + ONE;
                if (!dirty_d || (limit_q == ONE)) begin
                    // j is left alone so x/y keep showing the last compared pair.
                    state_d = DONE;
                end else begin
                    limit_d = limit_q - ONE;
                    j_d     = '0;
                    dirty_d = 1'b0;
                    state_d = CMP;
                end
            end
        end

        // Command outputs are decoded from the next state so they leave flops.
        x_d    = j_d;
        y_d    = j_d + ONE;
        init_d = (state_d == INIT);
        swap_d = (state_d == SWAP);
        busy_d = (state_d == INIT) || (state_d == CMP) || (state_d == SWAP);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            j_q        <= '0;
            limit_q    <= LIMIT_INIT;
            dirty_q    <= 1'b0;
            swap_cnt_q <= '0;
            pass_cnt_q <= '0;
            x_q        <= '0;
            y_q        <= ONE;
            init_q     <= 1'b0;
            swap_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            j_q        <= j_d;
            limit_q    <= limit_d;
            dirty_q    <= dirty_d;
            swap_cnt_q <= swap_cnt_d;
            pass_cnt_q <= pass_cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            init_q     <= init_d;
            swap_q     <= swap_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign init     = init_q;
    assign x        = x_q;
    assign y        = y_q;
    assign swap     = swap_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign swap_cnt = swap_cnt_q;
    assign pass_cnt = pass_cnt_q;

endmodule

// File: tb/tb_reg_sort_ctrl.sv
// tb/tb_reg_sort_ctrl.sv - bench for reg_sort_ctrl, descending and ascending instances
module tb_reg_sort_ctrl;

    typedef logic [7:0][3:0] arr_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_s [2];
    logic       ui_s    [2];
    arr_t       rf      [2];
    logic       ld      [2];
    arr_t       ld_val;
    arr_t       ident;

    logic       init_o  [2];
    logic [2:0] x_o     [2];
    logic [2:0] y_o     [2];
    logic       swap_o  [2];
    logic       busy_o  [2];
    logic       done_o  [2];
    logic [5:0] swcnt_o [2];
    logic [2:0] pcnt_o  [2];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    reg_sort_ctrl #(.N_REGS(8), .W(4), .DESCENDING(1'b1)) u_dut_desc (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start_s[0]),
        .use_init (ui_s[0]),
        .r_in     (rf[0]),
        .init     (init_o[0]),
        .x        (x_o[0]),
        .y        (y_o[0]),
        .swap     (swap_o[0]),
        .busy     (busy_o[0]),
        .done     (done_o[0]),
        .swap_cnt (swcnt_o[0]),
        .pass_cnt (pcnt_o[0])
    );

    reg_sort_ctrl #(.N_REGS(8), .W(4), .DESCENDING(1'b0)) u_dut_asc (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start_s[1]),
        .use_init (ui_s[1]),
        .r_in     (rf[1]),
        .init     (init_o[1]),
        .x        (x_o[1]),
        .y        (y_o[1]),
        .swap     (swap_o[1]),
        .busy     (busy_o[1]),
        .done     (done_o[1]),
        .swap_cnt (swcnt_o[1]),
        .pass_cnt (pcnt_o[1])
    );

    // Behavioural 8x4 swap register files, plus a bench-only preload port.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ld[k]) begin
                rf[k] <= ld_val;
            end else if (init_o[k]) begin
                for (int i = 0; i < 8; i++) rf[k][i] <= 4'(i);
            end else if (swap_o[k]) begin
                rf[k][x_o[k]] <= rf[k][y_o[k]];
                rf[k][y_o[k]] <= rf[k][x_o[k]];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_reset(input int k, input string tag);
        check_eq({tag, " init"},     32'(init_o[k]),  0);
        check_eq({tag, " swap"},     32'(swap_o[k]),  0);
        check_eq({tag, " busy"},     32'(busy_o[k]),  0);
        check_eq({tag, " done"},     32'(done_o[k]),  0);
        check_eq({tag, " x"},        32'(x_o[k]),     0);
        check_eq({tag, " y"},        32'(y_o[k]),     1);
        check_eq({tag, " swap_cnt"}, 32'(swcnt_o[k]), 0);
        check_eq({tag, " pass_cnt"}, 32'(pcnt_o[k]),  0);
    endtask

    task automatic preload(input int k, input arr_t v);
        @(negedge clk);
        ld[k]  = 1'b1;
        ld_val = v;
        @(negedge clk);
        ld[k]  = 1'b0;
    endtask

    // Runs one complete sort on instance k and compares everything observed
    // against a plain bubble sort of the expected starting contents.
    task automatic run_sort(input int k, input bit ui, input bit pre_en, input arr_t pre,
                            input bit hold, input string tag);
        arr_t a;
        logic [3:0] tmp;
        int exp_swaps, exp_passes, cmps, last_j, limit, ej;
        int busy_n, init_n, swp_n, cyc;
        bit dirty, fin;
        int q[$];

        if (pre_en) preload(k, pre);
        a = ui ? ident : rf[k];

        exp_swaps = 0; exp_passes = 0; cmps = 0; last_j = 0; limit = 7; fin = 0;
        while (!fin) begin
            dirty = 0;
            for (int j = 0; j < limit; j++) begin
                cmps++;
                last_j = j;
                if ((k == 0) ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
                    tmp = a[j]; a[j] = a[j+1]; a[j+1] = tmp;
                    exp_swaps++;
                    q.push_back(j);
                    dirty = 1;
                end
            end
            exp_passes++;
            if (!dirty || limit == 1) fin = 1;
            else limit--;
        end

        @(negedge clk);
        start_s[k] = 1'b1;
        ui_s[k]    = ui;
        @(negedge clk);
        if (!hold) start_s[k] = 1'b0;

        busy_n = 0; init_n = 0; swp_n = 0; cyc = 0;
        while (done_o[k] !== 1'b1 && cyc < 400) begin
            cyc++;
            if (busy_o[k]) busy_n++;
            if (init_o[k]) init_n++;
            if (swap_o[k]) begin
                swp_n++;
                ej = (q.size() > 0) ? q.pop_front() : -1;
                check_eq({tag, " swap x"}, 32'(x_o[k]), 32'(ej));
                check_eq({tag, " swap y"}, 32'(y_o[k]), 32'(ej + 1));
            end
            @(negedge clk);
        end
        start_s[k] = 1'b0;
        check_eq({tag, " finished in time"}, 32'(cyc < 400), 1);

        check_eq({tag, " busy cycles"}, 32'(busy_n), 32'(int'(ui) + cmps + exp_swaps));
        check_eq({tag, " init pulses"}, 32'(init_n), 32'(ui));
        check_eq({tag, " swap pulses"}, 32'(swp_n), 32'(exp_swaps));
        check_eq({tag, " swap_cnt"}, 32'(swcnt_o[k]), 32'((exp_swaps > 63) ? 63 : exp_swaps));
        check_eq({tag, " pass_cnt"}, 32'(pcnt_o[k]), 32'(exp_passes));
        check_eq({tag, " done x"}, 32'(x_o[k]), 32'(last_j));
        check_eq({tag, " done y"}, 32'(y_o[k]), 32'(last_j + 1));
        check_eq({tag, " done busy"}, 32'(busy_o[k]), 0);
        check_eq({tag, " result"}, rf[k], a);
    endtask

    initial begin
        arr_t v;
        int   cyc;

        for (int i = 0; i < 8; i++) ident[i] = 4'(i);
        for (int k = 0; k < 2; k++) begin
            start_s[k] = 1'b0; ui_s[k] = 1'b0; ld[k] = 1'b0; rf[k] = '0;
        end
        ld_val = '0;

        repeat (3) @(negedge clk);
        check_reset(0, "reset desc");
        check_reset(1, "reset asc");
        reset_n = 1'b1;

        // T2: init then full reverse sort (28 swaps, 7 passes, 57 busy cycles)
        run_sort(0, 1'b1, 1'b0, '0, 1'b0, "T2");
        // T3: already sorted, single clean pass
        run_sort(0, 1'b0, 1'b0, '0, 1'b0, "T3");
        // T4: ascending instance after init, no swaps
        run_sort(1, 1'b1, 1'b0, '0, 1'b0, "T4");
        // T5: all-equal contents never swap
        v = {8{4'd5}};
        run_sort(0, 1'b0, 1'b1, v, 1'b0, "T5d");
        run_sort(1, 1'b0, 1'b1, v, 1'b0, "T5a");
        // T6: start held through the sort, then restart from DONE
        for (int i = 0; i < 8; i++) v[i] = 4'($urandom_range(0, 15));
        run_sort(0, 1'b0, 1'b1, v, 1'b1, "T6 hold");
        run_sort(0, 1'b1, 1'b0, '0, 1'b1, "T6 restart");

        // T1: asynchronous reset while a swap is being issued
        preload(0, ident);
        @(negedge clk);
        start_s[0] = 1'b1; ui_s[0] = 1'b0;
        @(negedge clk);
        start_s[0] = 1'b0;
        cyc = 0;
        while (swap_o[0] !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("T1 reached swap", 32'(swap_o[0]), 1);
        #2 reset_n = 1'b0;
        #1 check_reset(0, "T1");
        @(negedge clk);
        reset_n = 1'b1;

        // Randomised sorts on both instances
        for (int it = 0; it < 24; it++) begin
            int mx;
            mx = ($urandom_range(0, 1) == 0) ? 2 : 15;
            for (int i = 0; i < 8; i++) v[i] = 4'($urandom_range(0, mx));
            run_sort(int'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                     1'b1, v, bit'($urandom_range(0, 1)), $sformatf("rnd%0d", it));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
